// File: rtl/timer_io.sv
// timer_io -- two-channel 16-bit timer/counter on the memory-mapped I/O bus.
//
// Each channel either counts system clocks (timing mode) or rising edges of
// an external, asynchronous pulse (counting mode), one-shot or auto-reload.
// A registered one-cycle terminal-count pulse is produced per channel.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-high reset
//   cs         chip-select from the I/O decoder
//   addr[2:0]  byte offset in the window; addr[2:1] selects the register
//   iord/iowr  read / write strobes
//   wdata      16-bit write data
//   rdata      16-bit read data, zero when not selected for read
//   pulse0_in  external count source, channel 0 (asynchronous)
//   pulse1_in  external count source, channel 1 (asynchronous)
//   cout0/1    one-cycle terminal-count pulses
//
// Bus semantics: there is no handshake. A write takes effect on every clock
// edge where cs && iowr is high. A read is combinational: rdata shows the
// selected register while cs && iord is high. A status read also clears the
// done flag on the clock edge where it is presented.
//
// Register map (addr[2:1]):
//   0: ch0 mode (wr) / ch0 status (rd)   1: ch1 mode (wr) / ch1 status (rd)
//   2: ch0 init (wr) / ch0 count  (rd)   3: ch1 init (wr) / ch1 count  (rd)
// Status word: {mode[1], mode[0], 12'b0, running, done}
module timer_io #(
  parameter int SYNC_STAGES = 2  // synchronizer depth, must be >= 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cs,
  input  logic [2:0]  addr,
  input  logic        iord,
  input  logic        iowr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic        pulse0_in,
  input  logic        pulse1_in,
  output logic        cout0,
  output logic        cout1
);

  logic       wr_en;
  logic       rd_en;
  logic [1:0] sel;
  logic [1:0] pulse_raw;
  logic       unused_addr0;

  assign wr_en        = cs && iowr;
  assign rd_en        = cs && iord;
  assign sel          = addr[2:1];
  assign pulse_raw    = {pulse1_in, pulse0_in};
  assign unused_addr0 = addr[0];

  // Per-channel state
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [1:0]             prev_q;     // last synchronized level, for edge detect
  logic [1:0]             mode_q [2];
  logic [1:0]             mode_d [2];
  logic [15:0]            init_q [2];
  logic [15:0]            init_d [2];
  logic [15:0]            count_q [2];
  logic [15:0]            count_d [2];
  logic [1:0]             done_q, done_d;
  logic [1:0]             run_q, run_d;
  logic [1:0]             cout_q, cout_d;
  logic [1:0]             tick;

  // Tick source: every clock in timing mode, one clock per synchronized
  // rising edge in counting mode.
  always_comb begin
    tick = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      if (mode_q[ch][0]) begin
        tick[ch] = sync_q[ch][SYNC_STAGES-1] & ~prev_q[ch];
      end else begin
        tick[ch] = 1'b1;
      end
    end
  end

  // Next-state logic. Priority per channel: a bus write to the channel beats
  // any tick or terminal event; a status-read clear is applied first so a
  // terminal event in the same cycle still leaves done set.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      mode_d[ch]  = mode_q[ch];
      init_d[ch]  = init_q[ch];
      count_d[ch] = count_q[ch];
      done_d[ch]  = done_q[ch];
      run_d[ch]   = run_q[ch];
      cout_d[ch]  = 1'b0;

      if (rd_en && (sel == 2'(ch))) begin
        done_d[ch] = 1'b0;
      end

      if (wr_en && (sel == 2'(ch))) begin
        mode_d[ch] = wdata[1:0];
        done_d[ch] = 1'b0;
        run_d[ch]  = 1'b0;
      end else if (wr_en && (sel == 2'(ch + 2))) begin
        init_d[ch]  = wdata;
        count_d[ch] = wdata;
        run_d[ch]   = |wdata;
      end else if (run_q[ch] && tick[ch]) begin
        if (count_q[ch] > 16'd1) begin
          count_d[ch] = count_q[ch] - 16'd1;
        end else begin
          // Terminal count
          done_d[ch] = 1'b1;
          cout_d[ch] = 1'b1;
          if (mode_q[ch][1]) begin
            count_d[ch] = init_q[ch];
          end else begin
            count_d[ch] = 16'd0;
            run_d[ch]   = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        sync_q[ch]  <= '0;
        mode_q[ch]  <= 2'b00;
        init_q[ch]  <= 16'd0;
        count_q[ch] <= 16'd0;
      end
      prev_q <= 2'b00;
      done_q <= 2'b00;
      run_q  <= 2'b00;
      cout_q <= 2'b00;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        sync_q[ch]  <= {sync_q[ch][SYNC_STAGES-2:0], pulse_raw[ch]};
        prev_q[ch]  <= sync_q[ch][SYNC_STAGES-1];
        mode_q[ch]  <= mode_d[ch];
        init_q[ch]  <= init_d[ch];
        count_q[ch] <= count_d[ch];
      end
      done_q <= done_d;
      run_q  <= run_d;
      cout_q <= cout_d;
    end
  end

  // Combinational read mux
  always_comb begin
    rdata = 16'h0000;
    if (rd_en) begin
      case (sel)
        2'd0:    rdata = {mode_q[0], 12'h000, run_q[0], done_q[0]};
        2'd1:    rdata = {mode_q[1], 12'h000, run_q[1], done_q[1]};
        2'd2:    rdata = count_q[0];
        default: rdata = count_q[1];
      endcase
    end
  end

  assign cout0 = cout_q[0];
  assign cout1 = cout_q[1];

endmodule

// File: tb/tb_timer_io.sv
// Testbench for timer_io: directed steps following the feature list, then a
// randomized bus/pulse phase, all checked against a behavioural model.
module tb_timer_io;
  localparam int S = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        cs, iord, iowr;
  logic [2:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        pulse0_in, pulse1_in;
  logic        cout0, cout1;

  timer_io #(.SYNC_STAGES(S)) dut (
    .clock(clock), .reset(reset), .cs(cs), .addr(addr), .iord(iord),
    .iowr(iowr), .wdata(wdata), .rdata(rdata), .pulse0_in(pulse0_in),
    .pulse1_in(pulse1_in), .cout0(cout0), .cout1(cout1)
  );

  // Clock / reset
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state
  logic [1:0]  m_mode [2];
  logic [15:0] m_init [2];
  logic [15:0] m_count [2];
  bit          m_done [2];
  bit          m_run [2];
  bit          m_cout [2];
  bit          hq0[$];   // pulse level seen at each clock edge, channel 0
  bit          hq1[$];

  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_mode[c] = 2'b00; m_init[c] = 16'd0; m_count[c] = 16'd0;
      m_done[c] = 0; m_run[c] = 0; m_cout[c] = 0;
    end
    hq0.delete(); hq1.delete();
    for (int k = 0; k < S + 2; k++) begin
      hq0.push_back(1'b0); hq1.push_back(1'b0);
    end
  endtask

  // One clock edge of the model, from the inputs currently driven.
  // A rising pulse level first seen at edge j produces a tick at edge j+S.
  task automatic model_update();
    bit tk [2];
    bit pt [2];
    int n;
    if (reset) begin
      model_reset();
      return;
    end
    hq0.push_back(pulse0_in); hq1.push_back(pulse1_in);
    n = hq0.size();
    pt[0] = hq0[n-1-S] && !hq0[n-2-S];
    pt[1] = hq1[n-1-S] && !hq1[n-2-S];
    if (hq0.size() > 16) begin
      void'(hq0.pop_front()); void'(hq1.pop_front());
    end
    for (int c = 0; c < 2; c++) begin
      tk[c] = m_mode[c][0] ? pt[c] : 1'b1;
      m_cout[c] = 0;
      if (cs && iord && addr[2:1] == c) m_done[c] = 0;
      if (cs && iowr && addr[2:1] == c) begin
        m_mode[c] = wdata[1:0]; m_done[c] = 0; m_run[c] = 0;
      end else if (cs && iowr && addr[2:1] == c + 2) begin
        m_init[c] = wdata; m_count[c] = wdata; m_run[c] = (wdata != 0);
      end else if (m_run[c] && tk[c]) begin
        if (m_count[c] > 1) m_count[c] = m_count[c] - 1;
        else begin
          m_done[c] = 1; m_cout[c] = 1;
          if (m_mode[c][1]) m_count[c] = m_init[c];
          else begin m_count[c] = 0; m_run[c] = 0; end
        end
      end
    end
  endtask

  function automatic logic [15:0] model_rdata();
    if (!(cs && iord)) return 16'h0000;
    case (addr[2:1])
      2'd0: return {m_mode[0], 12'h000, m_run[0], m_done[0]};
      2'd1: return {m_mode[1], 12'h000, m_run[1], m_done[1]};
      2'd2: return m_count[0];
      default: return m_count[1];
    endcase
  endfunction

  // Driver tasks
  task automatic step();
    model_update();
    @(posedge clock);
    #1;
    check("cout0", {15'd0, cout0}, {15'd0, m_cout[0]});
    check("cout1", {15'd0, cout1}, {15'd0, m_cout[1]});
    check("rdata", rdata, model_rdata());
  endtask

  task automatic idle();
    cs = 0; iord = 0; iowr = 0; addr = 3'd0; wdata = 16'h0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    cs = 1; iowr = 1; iord = 0; addr = a; wdata = d;
    step();
    idle();
  endtask

  // Presents a read and checks rdata; leaves the read asserted.
  task automatic peek(input logic [2:0] a);
    cs = 1; iord = 1; iowr = 0; addr = a;
    #1;
    check("peek", rdata, model_rdata());
  endtask

  int pulses;

  initial begin
    reset = 1; pulse0_in = 0; pulse1_in = 0;
    idle();
    model_reset();

    // 1. Reset state
    step(); step();
    reset = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      peek(3'(2 * i));
      check("reset_reg", rdata, 16'h0000);
    end
    check("reset_cout", {14'd0, cout1, cout0}, 16'h0000);
    idle();

    // 2. ch0 timing one-shot, init 5
    bus_write(3'd0, 16'h0000);
    bus_write(3'd4, 16'd5);
    exp_q = '{16'd4, 16'd3, 16'd2, 16'd1};
    peek(3'd4);
    for (int i = 0; i < 4; i++) begin
      step();
      check("os_count", rdata, exp_q.pop_front());
      check("os_nocout", {15'd0, cout0}, 16'd0);
    end
    step();
    check("os_cout", {15'd0, cout0}, 16'd1);
    check("os_zero", rdata, 16'd0);
    idle();
    step();
    check("os_cout_end", {15'd0, cout0}, 16'd0);
    peek(3'd0);
    check("os_status1", rdata, 16'h0001);
    step();
    idle();
    peek(3'd0);
    check("os_status2", rdata, 16'h0000);
    idle();

    // 3. ch1 timing auto-reload, init 3
    bus_write(3'd2, 16'h0002);
    bus_write(3'd6, 16'd3);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (cout1) pulses++;
    end
    check("ar_pulses", 16'(pulses), 16'd4);
    peek(3'd2);
    check("ar_status", rdata, 16'h8003);
    step();
    idle();
    bus_write(3'd2, 16'h0000);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (cout1) pulses++;
    end
    check("ar_stopped", 16'(pulses), 16'd0);
    peek(3'd2);
    check("ar_status_off", rdata, 16'h0000);
    idle();

    // 4. ch0 counting one-shot, init 4, edges 5 clocks apart
    bus_write(3'd0, 16'h0001);
    bus_write(3'd4, 16'd4);
    peek(3'd4);
    for (int i = 1; i <= 6; i++) begin
      pulse0_in = 1;
      step(); step();
      check("cnt_pre", rdata, (i <= 4) ? 16'(5 - i) : 16'd0);
      step();
      check("cnt_post", rdata, (i <= 4) ? 16'(4 - i) : 16'd0);
      check("cnt_cout", {15'd0, cout0}, (i == 4) ? 16'd1 : 16'd0);
      pulse0_in = 0;
      step(); step();
    end
    idle();

    // 5. ch0 auto-reload init 2, status read on the terminal edge
    bus_write(3'd0, 16'h0002);
    bus_write(3'd4, 16'd2);
    step();
    peek(3'd0);
    step();
    check("sim_cout", {15'd0, cout0}, 16'd1);
    idle();
    peek(3'd0);
    check("sim_done", rdata, 16'h8003);
    step();
    idle();
    bus_write(3'd4, 16'd7);
    check("wr_tick_cout", {15'd0, cout0}, 16'd0);
    peek(3'd4);
    check("wr_tick_cnt", rdata, 16'd7);
    idle();

    // 6. Reset mid-count
    bus_write(3'd0, 16'h0000);
    bus_write(3'd4, 16'h1234);
    step(); step();
    reset = 1;
    model_reset();
    peek(3'd4);
    check("rst_count", rdata, 16'h0000);
    peek(3'd0);
    check("rst_status", rdata, 16'h0000);
    check("rst_cout", {14'd0, cout1, cout0}, 16'h0000);
    idle();
    step();
    reset = 0;
    step(); step();
    bus_write(3'd4, 16'h0000);
    step();
    peek(3'd0);
    check("init0_status", rdata, 16'h0000);
    idle();

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      cs        = ($urandom_range(0, 3) != 0);
      iowr      = ($urandom_range(0, 9) == 0);
      iord      = $urandom_range(0, 1);
      addr      = 3'($urandom_range(0, 7));
      wdata     = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 2) == 0) pulse0_in = ~pulse0_in;
      if ($urandom_range(0, 2) == 0) pulse1_in = ~pulse1_in;
      #1;
      check("rand_rdata", rdata, model_rdata());
      step();
    end
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/timer_io.md
Name: timer_io

Overview:
- Two-channel 16-bit timer/counter peripheral on the memory-mapped I/O bus, window 0xFFFFFC20–0xFFFFFC2F.
- Acts as the responder for the CPU-side I/O decoder. It receives the timer chip-select, low address bits, read/write strobes and 16-bit write data, and returns 16-bit read data.
- Each channel runs in one of two modes:
  - timing mode: counts system clocks;
  - counting mode: counts rising edges of an external pulse.
- Each channel can run one-shot or auto-reload.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchronizer stages on each external pulse input (minimum 2).

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- cs  input  1  chip-select from the I/O decoder (timerCtrl).
- addr  input  3  caddress[2:0]; byte offset within window, addr[0] ignored.
- iord  input  1  I/O read strobe.
- iowr  input  1  I/O write strobe.
- wdata  input  16  write data (low half of the write bus).
- rdata  output  16  read data to the CPU; zero when not selected.
- pulse0_in  input  1  external count source, channel 0 (asynchronous).
- pulse1_in  input  1  external count source, channel 1 (asynchronous).
- cout0  output  1  one-cycle terminal-count pulse, channel 0.
- cout1  output  1  one-cycle terminal-count pulse, channel 1.

Behaviour:
- Register map, by addr[2:1]:
  - 0 = ch0 mode (write) / ch0 status (read).
  - 1 = ch1 mode (write) / ch1 status (read).
  - 2 = ch0 init (write) / ch0 current count (read).
  - 3 = ch1 init (write) / ch1 current count (read).
- Mode word:
  - bit0: 0 = timing, 1 = counting.
  - bit1: 0 = one-shot, 1 = auto-reload.
  - Other bits ignored.
- Status word:
  - bit0 = done (sticky).
  - bit1 = running.
  - bit15 = mode bit1, bit14 = mode bit0.
  - Remaining bits 0.
- Reset state (asynchronous): mode = 0, init = 0, count = 0, done = 0, running = 0, cout0/cout1 = 0, synchronizers = 0.
- Writes:
  - A write occurs on a clock edge with cs && iowr.
  - Mode write: sets mode, clears done and running, leaves count unchanged.
  - Init write: init ← wdata and count ← wdata. running ← 1 if wdata ≠ 0, else running ← 0. Done is unchanged.
  - An init write while running restarts from the new value.
- Reads:
  - rdata is combinational: rdata = selected register when cs && iord, else 16'h0000.
  - A status read clears done on the clock edge where cs && iord && addr[2:1] ∈ {0,1}.
- Tick source:
  - timing mode: tick = 1 every clock.
  - counting mode: tick = 1 for one clock per rising edge of pulseN_in after the SYNC_STAGES synchronizer plus an edge-detect flop. Edge-to-tick latency is SYNC_STAGES+1 clocks.
  - Edges shorter than one clock period may be lost.
- Per clock, when running && tick:
  - count > 1: count ← count − 1.
  - count == 1 (terminal):
    - done ← 1 and coutN ← 1 for exactly the next cycle.
    - auto-reload: count ← init, running stays 1.
    - one-shot: count ← 0, running ← 0.
  - Period = init ticks. Timing mode, one-shot, init N: cout is high during the cycle after the Nth clock edge following the write edge.
- coutN is registered and is 0 in every cycle other than the one following terminal count.
- Simultaneous events:
  - Terminal count and status read in the same cycle: done ends at 1 (set wins over clear).
  - Init write and tick in the same cycle: the write wins (count ← wdata, no decrement, no terminal event).
  - Mode write and terminal in the same cycle: the write wins (done ← 0, running ← 0, no cout).
- Unmapped or unselected accesses: writes ignored, rdata = 0. Both channels are fully independent.
- Reset asserted mid-count: all state is cleared immediately; no cout pulse after deassertion until reprogrammed.

Test Plan:
1. Reset, then read all four registers with cs=1 → rdata = 0x0000 each; cout0 = cout1 = 0.
2. Write ch0 mode = 0 (timing, one-shot), then ch0 init = 5 → count reads 4,3,2,1 on successive cycles. cout0 = 1 for exactly one cycle after the 5th edge. Then status = 0x0001; a second status read = 0x0000; count = 0.
3. Ch1 mode = 2 (timing, auto-reload), init = 3 → cout1 pulses every 3 cycles for ≥4 periods. Status = 0x8003 while running. A mode write of 0 stops it: no further pulses, status = 0x0000.
4. Ch0 mode = 1 (counting, one-shot), init = 4, toggle pulse0_in with 4 rising edges spaced 5 clocks apart → count decrements 3 clocks after each edge. cout0 pulses after the 4th edge. Further edges cause no change.
5. Auto-reload ch0, init = 2, status read issued on the exact terminal cycle → done reads back 1 afterwards. Init write of 7 on a tick cycle → count = 7, no cout.
6. Reset asserted mid-count with count = 0x1234 → count, status and cout = 0 immediately. Init = 0 write → running stays 0, status = 0x0000.
